// File: rtl/div_pkg.sv
// Shared types and default width for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        SUBTRACT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int DIV_N = 4;

endpackage

// File: rtl/div_regs.sv
// Divider register file: partial remainder R, quotient/dividend Q, divisor D,
// plus the trial subtractor and restore mux.
module div_regs
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic         sub_i,
    input  logic         loadz_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] quot_o,
    output logic [N-1:0] rem_o
);

    logic [N:0]   r_q, r_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] d_q, d_d;
    logic [N:0]   diff;

    always_comb begin
        r_d  = r_q;
        q_d  = q_q;
        d_d  = d_q;
        diff = r_q - {1'b0, d_q};
        if (loadz_i) begin
            r_d = {1'b0, dividend_i};
            q_d = '1;
            d_d = divisor_i;
        end else if (load_i) begin
            r_d = '0;
            q_d = dividend_i;
            d_d = divisor_i;
        end else if (shift_i) begin
            {r_d, q_d} = {r_q, q_q} << 1;
        end else if (sub_i && !diff[N]) begin
            // Trial subtraction did not borrow: keep it and set the quotient bit.
            r_d    = diff;
            q_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
            q_q <= '0;
            d_q <= '0;
        end else begin
            r_q <= r_d;
            q_q <= q_d;
            d_q <= d_d;
        end
    end

    assign quot_o = q_q;
    assign rem_o  = r_q[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: FSM, iteration counter and handshake flags
// driving the div_regs datapath, one quotient bit per SHIFT/SUBTRACT pair.
module seq_divider
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic         dbz,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    localparam int CW = $clog2(N + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;
    logic          busy_q, done_q;
    logic          load, shift_en, sub_en, loadz;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dbz_d    = dbz_q;
        load     = 1'b0;
        shift_en = 1'b0;
        sub_en   = 1'b0;
        loadz    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        loadz   = 1'b1;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        load    = 1'b1;
                        cnt_d   = CW'(N);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                state_d  = SUBTRACT;
            end
            SUBTRACT: begin
                sub_en  = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? DONE : SHIFT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy/done are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            busy_q  <= (state_d == SHIFT) || (state_d == SUBTRACT);
            done_q  <= (state_d == DONE);
        end
    end

    div_regs #(.N(N)) u_regs (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .shift_i    (shift_en),
        .sub_i      (sub_en),
        .loadz_i    (loadz),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .quot_o     (quotient),
        .rem_o      (remainder)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=4): directed table, handshake corner
// sequences and a shuffled sweep of all operand pairs against arithmetic.
module tb_seq_divider;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic         dbz;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        int           q;
        int           r;
        int           dz;
        int           lat;
        int           bsy;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Called just after an edge, in an IDLE cycle. Issues start in this cycle
    // and records latency (edges after issue until done), busy cycles, done width.
    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                           output int lat, output int busy_n, output int done_n,
                           output int qo, output int ro, output int dz);
        lat = -1; busy_n = 0; done_n = 0; qo = -1; ro = -1; dz = -1;
        start = 1'b1; dividend = a; divisor = b;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat < 0) begin
                    lat = k; qo = int'(quotient); ro = int'(remainder); dz = int'(dbz);
                end
            end
            if (lat >= 0 && k >= lat + 1) break;
        end
    endtask

    // Waits (bounded) for done; returns edges waited, or -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    vec_t vecs[7];
    int   order[256];

    initial begin
        int lat, bn, dn, qo, ro, dz, n, tmp, j, a, b, eq, er, ed;

        vecs[0] = '{a: 4'd13, b: 4'd3,  q: 4,  r: 1, dz: 0, lat: 9, bsy: 8};
        vecs[1] = '{a: 4'd15, b: 4'd1,  q: 15, r: 0, dz: 0, lat: 9, bsy: 8};
        vecs[2] = '{a: 4'd15, b: 4'd15, q: 1,  r: 0, dz: 0, lat: 9, bsy: 8};
        vecs[3] = '{a: 4'd5,  b: 4'd7,  q: 0,  r: 5, dz: 0, lat: 9, bsy: 8};
        vecs[4] = '{a: 4'd0,  b: 4'd6,  q: 0,  r: 0, dz: 0, lat: 9, bsy: 8};
        vecs[5] = '{a: 4'd9,  b: 4'd0,  q: 15, r: 9, dz: 1, lat: 1, bsy: 0};
        vecs[6] = '{a: 4'd0,  b: 4'd0,  q: 15, r: 0, dz: 1, lat: 1, bsy: 0};

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset dbz", int'(dbz), 0);
        chk("reset quotient", int'(quotient), 0);
        chk("reset remainder", int'(remainder), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed table, issued back-to-back.
        for (int i = 0; i < 7; i++) begin
            run_div(vecs[i].a, vecs[i].b, lat, bn, dn, qo, ro, dz);
            chk($sformatf("vec%0d %0d/%0d quotient", i, vecs[i].a, vecs[i].b), qo, vecs[i].q);
            chk($sformatf("vec%0d remainder", i), ro, vecs[i].r);
            chk($sformatf("vec%0d dbz", i), dz, vecs[i].dz);
            chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d busy cycles", i), bn, vecs[i].bsy);
            chk($sformatf("vec%0d done width", i), dn, 1);
        end

        // Results hold in IDLE until the next start.
        repeat (3) @(posedge clk);
        #1;
        chk("hold quotient", int'(quotient), 15);
        chk("hold remainder", int'(remainder), 0);
        chk("hold dbz", int'(dbz), 1);

        // start held high with new operands during busy and DONE is ignored.
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(posedge clk); #1;
        dividend = 4'd15; divisor = 4'd1;
        wait_done(n);
        chk("ignore-start latency", n + 1, 9);
        chk("ignore-start quotient", int'(quotient), 4);
        chk("ignore-start remainder", int'(remainder), 1);
        @(posedge clk); #1;
        chk("ignore-start idle busy", int'(busy), 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("ignore-start accepted in idle", int'(busy), 1);
        wait_done(n);
        chk("second latency", n + 1, 9);
        chk("second quotient", int'(quotient), 15);
        chk("second remainder", int'(remainder), 0);
        @(posedge clk); #1;

        // Reset in the cycle after E4 of a 13/3 division.
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        repeat (4) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("pre-reset busy", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid reset busy", int'(busy), 0);
        chk("mid reset done", int'(done), 0);
        chk("mid reset dbz", int'(dbz), 0);
        chk("mid reset quotient", int'(quotient), 0);
        chk("mid reset remainder", int'(remainder), 0);
        run_div(4'd12, 4'd5, lat, bn, dn, qo, ro, dz);
        chk("post-reset 12/5 quotient", qo, 2);
        chk("post-reset 12/5 remainder", ro, 2);
        chk("post-reset 12/5 latency", lat, 9);

        // All 256 operand pairs in shuffled order vs plain arithmetic.
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            a = order[i] / 16;
            b = order[i] % 16;
            if (b == 0) begin
                eq = 15; er = a; ed = 1;
            end else begin
                eq = a / b; er = a % b; ed = 0;
            end
            run_div(N'(a), N'(b), lat, bn, dn, qo, ro, dz);
            chk($sformatf("sweep %0d/%0d quotient", a, b), qo, eq);
            chk($sformatf("sweep %0d/%0d remainder", a, b), ro, er);
            chk($sformatf("sweep %0d/%0d dbz", a, b), dz, ed);
            chk($sformatf("sweep %0d/%0d done width", a, b), dn, 1);
            chk($sformatf("sweep %0d/%0d latency", a, b), lat, (b == 0) ? 1 : 2 * N + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
